// File: rtl/skew_fifo_bank.sv
// Bank of CHANNELS independent delay lines, BITS wide, MAX_DEPTH stages each.
// A per-lane tap, chosen by mode, skews operands into the array, deskews
// results leaving it, or applies a uniform delay. Each entry carries a valid
// bit alongside its data. A synchronous flush clears the bank.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            advance every lane by one stage
//   clr           synchronous flush of all data and valid stages
//   mode          0 uniform, 1 skew, 2 deskew, 3 reserved (acts as uniform)
//   d, d_valid    lane i input at d[i*BITS +: BITS] and d_valid[i]
//   q, q_valid    per-lane tap outputs, packed the same way as d
//   busy          a valid entry sits at or before some lane's current tap
module skew_fifo_bank #(
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned BITS      = 64,
  parameter int unsigned MAX_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic [CHANNELS*BITS-1:0]   d,
  input  logic [CHANNELS-1:0]        d_valid,
  output logic [CHANNELS*BITS-1:0]   q,
  output logic [CHANNELS-1:0]        q_valid,
  output logic                       busy
);

  localparam logic [1:0] MODE_SKEW   = 2'd1;
  localparam logic [1:0] MODE_DESKEW = 2'd2;

  // Stage 0 is the newest entry of each lane.
  logic [BITS-1:0]      s [CHANNELS][MAX_DEPTH];
  logic [MAX_DEPTH-1:0] v [CHANNELS];

  // Zero-based stage index of lane's tap for the given mode.
  function automatic int unsigned tap_idx(input int unsigned lane, input logic [1:0] m);
    case (m)
      MODE_SKEW:   tap_idx = lane;
      MODE_DESKEW: tap_idx = CHANNELS - 1 - lane;
      default:     tap_idx = CHANNELS - 1;
    endcase
  endfunction

  // Shift register bank: reset and flush clear everything, en advances all lanes.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        v[i] <= '0;
        for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
          s[i][k] <= '0;
        end
      end
    end else if (en) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        s[i][0] <= d[i*BITS +: BITS];
        v[i][0] <= d_valid[i];
        for (int unsigned k = 1; k < MAX_DEPTH; k++) begin
          s[i][k] <= s[i][k-1];
          v[i][k] <= v[i][k-1];
        end
      end
    end
  end

  // Tap mux and busy: purely combinational over registered stages.
  always_comb begin
    q       = '0;
    q_valid = '0;
    busy    = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
        if (k == tap_idx(i, mode)) begin
          q[i*BITS +: BITS] = s[i][k];
          q_valid[i]        = v[i][k];
        end
        if (k <= tap_idx(i, mode)) begin
          busy = busy | v[i][k];
        end
      end
    end
  end

endmodule

// File: tb/tb_skew_fifo_bank.sv
// Randomised and directed bench for skew_fifo_bank (4 lanes x 8 bits, depth 4).
// The reference model keeps the history of accepted input words and reads
// each lane's output as the word accepted T(i) en-edges ago.
module tb_skew_fifo_bank;
  localparam int CH = 4;
  localparam int BW = 8;
  localparam int MD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            clr = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [CH*BW-1:0] d = '0;
  logic [CH-1:0]   d_valid = '0;
  logic [CH*BW-1:0] q;
  logic [CH-1:0]   q_valid;
  logic            busy;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [CH*BW-1:0] d;
    logic [CH-1:0]    v;
  } ent_t;
  ent_t hist[$];

  skew_fifo_bank #(.CHANNELS(CH), .BITS(BW), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .d(d), .d_valid(d_valid), .q(q), .q_valid(q_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int tdepth(input int lane);
    case (mode)
      2'd1:    return lane + 1;
      2'd2:    return CH - lane;
      default: return CH;
    endcase
  endfunction

  function automatic logic [CH*BW-1:0] exp_q();
    logic [CH*BW-1:0] r = '0;
    ent_t e;
    for (int i = 0; i < CH; i++) begin
      if (hist.size() >= tdepth(i)) begin
        e = hist[hist.size() - tdepth(i)];
        r[i*BW +: BW] = e.d[i*BW +: BW];
      end
    end
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_qv();
    logic [CH-1:0] r = '0;
    ent_t e;
    for (int i = 0; i < CH; i++) begin
      if (hist.size() >= tdepth(i)) begin
        e = hist[hist.size() - tdepth(i)];
        r[i] = e.v[i];
      end
    end
    return r;
  endfunction

  function automatic logic exp_busy();
    logic r = 1'b0;
    ent_t e;
    for (int i = 0; i < CH; i++) begin
      for (int j = 1; j <= tdepth(i); j++) begin
        if (hist.size() >= j) begin
          e = hist[hist.size() - j];
          r = r | e.v[i];
        end
      end
    end
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge happen, update the model.
  task automatic tick(input logic t_rst, input logic t_clr, input logic t_en,
                      input logic [CH*BW-1:0] t_d, input logic [CH-1:0] t_dv);
    rst = t_rst; clr = t_clr; en = t_en; d = t_d; d_valid = t_dv;
    @(posedge clk);
    if (t_rst || t_clr) hist.delete();
    else if (t_en) begin
      hist.push_back('{d: t_d, v: t_dv});
      if (hist.size() > MD) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      tick(1'b1, 1'b0, 1'b1, '1, '1);
      total++;
      if (q !== '0 || q_valid !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset c%0d: q=%h qv=%h busy=%b, want all zero", c, q, q_valid, busy);
      end
    end
    tick(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_skew();
    logic [BW-1:0] want [CH] = '{8'h11, 8'h22, 8'h33, 8'h44};
    mode = 2'd1;
    tick(1'b0, 1'b0, 1'b1, 32'h44332211, 4'hF);
    for (int e = 1; e <= 5; e++) begin
      total++;
      if (q !== exp_q() || q_valid !== exp_qv() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL skew edge%0d: q=%h qv=%h busy=%b want q=%h qv=%h busy=%b",
                 e, q, q_valid, busy, exp_q(), exp_qv(), exp_busy());
      end
      if (e <= CH) begin
        total++;
        if (q[(e-1)*BW +: BW] !== want[e-1] || q_valid[e-1] !== 1'b1) begin
          bad++;
          $display("FAIL skew lane%0d: got %h/%b want %h/1", e - 1, q[(e-1)*BW +: BW],
                   q_valid[e-1], want[e-1]);
        end
      end
      if (e == 5) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL skew busy_drop: busy=%b want 0", busy);
        end
      end else tick(1'b0, 1'b0, 1'b1, '0, '0);
    end
  endtask

  task automatic test_deskew();
    logic [CH*BW-1:0] dd;
    mode = 2'd2;
    tick(1'b0, 1'b1, 1'b0, '0, '0);
    for (int c = 0; c < CH; c++) begin
      dd = '0;
      dd[c*BW +: BW] = BW'(8'hC0 + c);
      tick(1'b0, 1'b0, 1'b1, dd, CH'(1 << c));
      total++;
      if (q !== exp_q() || q_valid !== exp_qv() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL deskew edge%0d: q=%h qv=%h busy=%b want q=%h qv=%h busy=%b",
                 c + 1, q, q_valid, busy, exp_q(), exp_qv(), exp_busy());
      end
    end
    total++;
    if (q_valid !== 4'hF || q !== 32'hC3C2C1C0) begin
      bad++;
      $display("FAIL deskew align: q=%h qv=%h want c3c2c1c0/f", q, q_valid);
    end
  endtask

  task automatic test_stall();
    mode = 2'd0;
    tick(1'b0, 1'b1, 1'b0, '0, '0);
    tick(1'b0, 1'b0, 1'b1, 32'h000000A5, 4'h1);
    for (int c = 2; c <= 7; c++) begin
      tick(1'b0, 1'b0, (c > 4), '0, '0);
      total++;
      if (q[BW-1:0] !== ((c == 7) ? 8'hA5 : 8'h00) || busy !== exp_busy() || q_valid !== exp_qv()) begin
        bad++;
        $display("FAIL stall wall%0d: lane0=%h busy=%b qv=%h want %h busy=%b qv=%h", c,
                 q[BW-1:0], busy, q_valid, (c == 7) ? 8'hA5 : 8'h00, exp_busy(), exp_qv());
      end
    end
  endtask

  task automatic test_flush();
    mode = 2'd0;
    tick(1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF);
    tick(1'b0, 1'b0, 1'b1, 32'h05060708, 4'hF);
    tick(1'b0, 1'b1, 1'b1, 32'h5A5A5A5A, 4'hF);
    total++;
    if (q !== '0 || q_valid !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL flush clear: q=%h qv=%h busy=%b want 0/0/0", q, q_valid, busy);
    end
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 1'b0, 1'b1, '0, '0);
      total++;
      if (q !== '0 || q_valid !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL flush after%0d: q=%h qv=%h busy=%b want 0/0/0", c, q, q_valid, busy);
      end
    end
  endtask

  task automatic test_overflow();
    mode = 2'd0;
    tick(1'b0, 1'b1, 1'b0, '0, '0);
    for (int e = 1; e <= 7; e++) begin
      tick(1'b0, 1'b0, 1'b1, (e <= 6) ? 32'(e) : 32'h0, (e <= 6) ? 4'h1 : 4'h0);
      if (e >= 4) begin
        total++;
        if (q[BW-1:0] !== BW'(e - 3) || q_valid[0] !== 1'b1) begin
          bad++;
          $display("FAIL overflow edge%0d: lane0=%h/%b want %h/1", e, q[BW-1:0], q_valid[0],
                   BW'(e - 3));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [CH*BW-1:0] rd;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      rd = {$urandom};
      tick($urandom_range(0, 60) == 0, $urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0,
           rd, CH'($urandom));
      total++;
      if (q !== exp_q() || q_valid !== exp_qv() || busy !== exp_busy()) begin
        bad++;
        $display("FAIL random c%0d m%0d: q=%h qv=%h busy=%b want q=%h qv=%h busy=%b",
                 c, mode, q, q_valid, busy, exp_q(), exp_qv(), exp_busy());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_skew();
    test_deskew();
    test_stall();
    test_flush();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
